// File: rtl/ibus_periph_bridge_pkg.sv
package ibus_periph_bridge_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    WORD = 2'd1,
    LONG = 2'd2
  } IBUS_SIZE_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BEAT = 2'd1,
    RESP = 2'd2
  } BRIDGE_STATE_t;

  localparam logic [31:0] PERIPH_BYTE_BASE = 32'hFFFF_FE00;
  localparam logic [31:0] PERIPH_BYTE_LAST = 32'hFFFF_FEFF;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    return (size == WORD && a[0]) || (size == LONG && a != 2'b00) || (size == 2'd3);
  endfunction

endpackage

// File: rtl/ibus_lane_sel.sv
module ibus_lane_sel
  import ibus_periph_bridge_pkg::*;
(
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic [31:0] rdata,
  input  logic [31:0] merge_in,
  output logic [3:0]  ba,
  output logic [31:0] merge_out
);

  always_comb begin
    ba = '0;
    case (size)
      BYTE:    ba = 4'b1000 >> addr;
      WORD:    ba = addr[1] ? 4'b0011 : 4'b1100;
      default: ba = 4'b1111;
    endcase
  end

  always_comb begin
    merge_out = merge_in;
    for (int unsigned i = 0; i < 4; i++) begin
      if (ba[i]) merge_out[8*i +: 8] = rdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/ibus_periph_bridge.sv
module ibus_periph_bridge
  import ibus_periph_bridge_pkg::*;
#(
  parameter logic [31:0] BYTE_BASE = PERIPH_BYTE_BASE,
  parameter logic [31:0] BYTE_LAST = PERIPH_BYTE_LAST,
  parameter int unsigned BUSY_TMO  = 16
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic [31:0] M_A,
  input  logic [31:0] M_DI,
  input  logic [1:0]  M_SIZE,
  input  logic        M_WE,
  input  logic        M_REQ,
  output logic [31:0] M_DO,
  output logic        M_ACK,
  output logic        M_ERR,
  output logic        M_BUSY,
  output logic [31:0] IBUS_A,
  output logic [31:0] IBUS_DI,
  output logic [3:0]  IBUS_BA,
  output logic        IBUS_WE,
  output logic        IBUS_REQ,
  input  logic [31:0] IBUS_DO,
  input  logic        IBUS_BUSY,
  input  logic        IBUS_ACT
);

  localparam int unsigned TMO_W = $clog2(BUSY_TMO + 1);

  BRIDGE_STATE_t    state_q, state_d;
  logic [31:0]      a_q, a_d, di_q, di_d, asm_q, asm_d;
  logic [1:0]       size_q, size_d, idx_q, idx_d, last_q, last_d;
  logic             we_q, we_d, split_q, split_d, err_q, err_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic [31:0]      beat_a;
  logic [1:0]       beat_size;
  logic [3:0]       beat_ba;
  logic [31:0]      beat_merge;
  logic             in_win;
  logic [TMO_W-1:0] tmo_inc;
  logic             unused_ce_f;

  assign unused_ce_f = CE_F;
  assign in_win      = (M_A >= BYTE_BASE) && (M_A <= BYTE_LAST);
  assign beat_a      = a_q + {30'd0, idx_q};
  // split beats are issued as byte accesses at the incremented address
  assign beat_size   = split_q ? 2'(BYTE) : size_q;
  assign tmo_inc     = tmo_q + TMO_W'(1);

  ibus_lane_sel u_lane_sel (
    .addr      (beat_a[1:0]),
    .size      (beat_size),
    .rdata     (IBUS_DO),
    .merge_in  (asm_q),
    .ba        (beat_ba),
    .merge_out (beat_merge)
  );

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= IDLE;
      a_q     <= '0;
      di_q    <= '0;
      asm_q   <= '0;
      size_q  <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      we_q    <= 1'b0;
      split_q <= 1'b0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else if (CE_R) begin
      state_q <= state_d;
      a_q     <= a_d;
      di_q    <= di_d;
      asm_q   <= asm_d;
      size_q  <= size_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      we_q    <= we_d;
      split_q <= split_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    di_d    = di_q;
    asm_d   = asm_q;
    size_d  = size_q;
    idx_d   = idx_q;
    last_d  = last_q;
    we_d    = we_q;
    split_d = split_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        if (M_REQ) begin
          a_d     = M_A;
          di_d    = M_DI;
          size_d  = M_SIZE;
          we_d    = M_WE;
          idx_d   = '0;
          tmo_d   = '0;
          asm_d   = '0;
          split_d = in_win && (M_SIZE != BYTE);
          last_d  = !in_win          ? 2'd0 :
                    (M_SIZE == WORD) ? 2'd1 :
                    (M_SIZE == LONG) ? 2'd3 : 2'd0;
          err_d   = misaligned(M_SIZE, M_A[1:0]);
          state_d = err_d ? RESP : BEAT;
        end
      end
      BEAT: begin
        if (!IBUS_ACT) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else if (IBUS_BUSY) begin
          tmo_d = tmo_inc;
          if (tmo_inc == TMO_W'(BUSY_TMO)) begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end else begin
          asm_d = beat_merge;
          tmo_d = '0;
          if (idx_q == last_q) state_d = RESP;
          else                 idx_d   = idx_q + 2'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    M_DO     = '0;
    M_ACK    = 1'b0;
    M_ERR    = 1'b0;
    M_BUSY   = (state_q != IDLE);
    IBUS_A   = '0;
    IBUS_DI  = '0;
    IBUS_BA  = '0;
    IBUS_WE  = 1'b0;
    IBUS_REQ = 1'b0;
    case (state_q)
      BEAT: begin
        IBUS_REQ = 1'b1;
        IBUS_A   = beat_a;
        IBUS_DI  = di_q;
        IBUS_BA  = beat_ba;
        IBUS_WE  = we_q;
      end
      RESP: begin
        M_ACK = 1'b1;
        M_ERR = err_q;
        M_DO  = (we_q || err_q) ? '0 : asm_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ibus_periph_bridge.sv
module tb_ibus_periph_bridge;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CE_R = 1'b0;
  logic        CE_F = 1'b0;
  logic [31:0] M_A = '0;
  logic [31:0] M_DI = '0;
  logic [1:0]  M_SIZE = '0;
  logic        M_WE = 1'b0;
  logic        M_REQ = 1'b0;
  logic [31:0] M_DO;
  logic        M_ACK, M_ERR, M_BUSY;
  logic [31:0] IBUS_A, IBUS_DI;
  logic [3:0]  IBUS_BA;
  logic        IBUS_WE, IBUS_REQ;
  logic [31:0] IBUS_DO;
  logic        IBUS_BUSY, IBUS_ACT;

  ibus_periph_bridge dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F),
    .M_A(M_A), .M_DI(M_DI), .M_SIZE(M_SIZE), .M_WE(M_WE), .M_REQ(M_REQ),
    .M_DO(M_DO), .M_ACK(M_ACK), .M_ERR(M_ERR), .M_BUSY(M_BUSY),
    .IBUS_A(IBUS_A), .IBUS_DI(IBUS_DI), .IBUS_BA(IBUS_BA), .IBUS_WE(IBUS_WE),
    .IBUS_REQ(IBUS_REQ), .IBUS_DO(IBUS_DO), .IBUS_BUSY(IBUS_BUSY), .IBUS_ACT(IBUS_ACT)
  );

  always #5 CLK = ~CLK;

  int unsigned cyc = 0;
  always @(negedge CLK) begin
    cyc++;
    CE_R = (cyc % 4) != 0;
    CE_F = !CE_R;
  end

  int n_checks = 0;
  int n_fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Responder: timer FRC with TEMP latch at FE12/FE13, other window bytes echo A[7:0]
  logic [15:0] frc = 16'h1234;
  logic [7:0]  temp = 8'h00;
  logic [7:0]  rsp_byte;
  int unsigned busy_left = 0, busy_cfg = 0, busy_gen = 0, busy_seen_gen = 0;

  always @* begin
    rsp_byte  = (IBUS_A == 32'hFFFFFE12) ? frc[15:8] :
                (IBUS_A == 32'hFFFFFE13) ? temp : IBUS_A[7:0];
    IBUS_ACT  = 1'b1;
    IBUS_DO   = 32'hEEEEEEEE;
    if (IBUS_A[31:8] == 24'hFFFFFE)      IBUS_DO[8 * (3 - int'(IBUS_A[1:0])) +: 8] = rsp_byte;
    else if (IBUS_A[31:8] == 24'hFFFFFF) IBUS_DO = 32'hCAFEF00D;
    else if (IBUS_A[31:8] == 24'hFFFFFD) IBUS_DO = 32'h11223344;
    else begin
      IBUS_ACT = 1'b0;
      IBUS_DO  = 32'hDEADBEEF;
    end
    IBUS_BUSY = (busy_left != 0);
  end

  logic        snap_req = 1'b0, snap_we = 1'b0, snap_act = 1'b0, snap_busy = 1'b0;
  logic [31:0] snap_a = '0, snap_di = '0;
  logic [3:0]  snap_ba = '0;
  logic        dut_idle = 1'b1;
  logic        beat_done = 1'b0, ce_at_edge = 1'b0;
  int unsigned tick_cnt = 0, req_tick = 0;

  always @(posedge CLK) begin
    ce_at_edge <= CE_R && RST_N;
    if (CE_R) tick_cnt <= tick_cnt + 1;
    if (CE_R && RST_N && M_REQ && dut_idle) req_tick <= tick_cnt;
    beat_done <= CE_R && RST_N && snap_req && snap_act && !snap_busy;
    if (busy_gen != busy_seen_gen) begin
      busy_seen_gen <= busy_gen;
      busy_left     <= busy_cfg;
    end else if (CE_R && RST_N && snap_req && snap_act && busy_left != 0) begin
      busy_left <= busy_left - 1;
    end
    if (CE_R && RST_N && snap_req && snap_act && !snap_busy) begin
      if (!snap_we && snap_a == 32'hFFFFFE12) temp <= frc[7:0];
      if (snap_we && snap_a == 32'hFFFFFE12)  temp <= snap_di[15:8];
      if (snap_we && snap_a == 32'hFFFFFE13)  frc  <= {temp, snap_di[7:0]};
    end
  end

  typedef struct { logic [31:0] d; logic e; int unsigned lat; } ack_t;
  typedef struct { logic [31:0] a; logic [3:0] ba; logic we; logic [31:0] di; } beat_t;
  ack_t  exp_ack[$];
  beat_t exp_beat[$];
  ack_t  cur_ack;
  beat_t cur_beat;
  int unsigned acks_seen = 0;

  always @(negedge CLK) begin
    if (beat_done) begin
      if (exp_beat.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_beat: got A=%h BA=%b expected no beat", snap_a, snap_ba);
      end else begin
        cur_beat = exp_beat.pop_front();
        check("beat_a_ba_we_di", {snap_a, snap_ba, snap_we, snap_di},
              {cur_beat.a, cur_beat.ba, cur_beat.we, cur_beat.di});
      end
    end
    if (ce_at_edge && M_ACK) begin
      acks_seen++;
      if (exp_ack.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_ack: got ack DO=%h ERR=%b expected none", M_DO, M_ERR);
      end else begin
        cur_ack = exp_ack.pop_front();
        check("ack_do", M_DO, cur_ack.d);
        check("ack_err", M_ERR, cur_ack.e);
        check("ack_latency", tick_cnt - req_tick, cur_ack.lat);
      end
    end
    dut_idle  = !M_BUSY;
    snap_req  = IBUS_REQ;
    snap_a    = IBUS_A;
    snap_ba   = IBUS_BA;
    snap_we   = IBUS_WE;
    snap_di   = IBUS_DI;
    snap_act  = IBUS_ACT;
    snap_busy = IBUS_BUSY;
  end

  logic last_saw_req;

  task automatic beat(input logic [31:0] a, input logic [3:0] ba, input logic we, input logic [31:0] di);
    exp_beat.push_back('{a, ba, we, di});
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] di, input logic [1:0] sz, input logic we);
    int unsigned n;
    n = 0;
    while (M_BUSY !== 1'b0 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    M_A = a; M_DI = di; M_SIZE = sz; M_WE = we; M_REQ = 1'b1;
    n = 0;
    do begin
      @(posedge CLK);
      n++;
    end while (!CE_R && n < 20);
    @(negedge CLK);
    M_REQ = 1'b0;
  endtask

  task automatic access(input logic [31:0] a, input logic [31:0] di, input logic [1:0] sz,
                        input logic we, input logic [31:0] ed, input logic ee, input int unsigned el);
    int unsigned start, n;
    exp_ack.push_back('{ed, ee, el});
    start = acks_seen;
    last_saw_req = 1'b0;
    issue(a, di, sz, we);
    n = 0;
    while (acks_seen == start && n < 100) begin
      last_saw_req |= IBUS_REQ;
      @(negedge CLK);
      n++;
    end
    if (acks_seen == start) begin
      n_checks++;
      n_fails++;
      $display("FAIL ack_timeout: got no ack expected ack for A=%h", a);
      exp_ack.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    repeat (4) @(negedge CLK);
    check("reset_outputs", {M_DO, M_ACK, M_ERR, M_BUSY, IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE, IBUS_REQ}, '0);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    beat(32'hFFFFFE12, 4'b0010, 1'b0, 32'h0);
    beat(32'hFFFFFE13, 4'b0001, 1'b0, 32'h0);
    access(32'hFFFFFE12, 32'h0, 2'd1, 1'b0, 32'h0000_1234, 1'b0, 3);

    beat(32'hFFFFFE12, 4'b0010, 1'b1, 32'h0000ABCD);
    beat(32'hFFFFFE13, 4'b0001, 1'b1, 32'h0000ABCD);
    access(32'hFFFFFE12, 32'h0000ABCD, 2'd1, 1'b1, 32'h0, 1'b0, 3);
    check("model_frc", frc, 16'hABCD);

    beat(32'hFFFFFF00, 4'b1111, 1'b0, 32'h0);
    access(32'hFFFFFF00, 32'h0, 2'd2, 1'b0, 32'hCAFEF00D, 1'b0, 2);

    access(32'hFFFFFE11, 32'h0, 2'd1, 1'b0, 32'h0, 1'b1, 1);
    check("misaligned_no_req", last_saw_req, 1'b0);
    access(32'hFFFFFE40, 32'h0, 2'd3, 1'b0, 32'h0, 1'b1, 1);
    check("size3_no_req", last_saw_req, 1'b0);
    access(32'hFFFFFF02, 32'h0, 2'd2, 1'b0, 32'h0, 1'b1, 1);

    access(32'hFFFFFC00, 32'h0, 2'd2, 1'b0, 32'h0, 1'b1, 2);

    beat(32'hFFFFFE40, 4'b1000, 1'b0, 32'h0);
    beat(32'hFFFFFE41, 4'b0100, 1'b0, 32'h0);
    beat(32'hFFFFFE42, 4'b0010, 1'b0, 32'h0);
    beat(32'hFFFFFE43, 4'b0001, 1'b0, 32'h0);
    access(32'hFFFFFE40, 32'h0, 2'd2, 1'b0, 32'h40414243, 1'b0, 5);

    beat(32'hFFFFFE41, 4'b0100, 1'b0, 32'h0);
    access(32'hFFFFFE41, 32'h0, 2'd0, 1'b0, 32'h00410000, 1'b0, 2);

    beat(32'hFFFFFF02, 4'b0011, 1'b0, 32'h0);
    access(32'hFFFFFF02, 32'h0, 2'd1, 1'b0, 32'h0000F00D, 1'b0, 2);

    beat(32'hFFFFFEFE, 4'b0010, 1'b0, 32'h0);
    beat(32'hFFFFFEFF, 4'b0001, 1'b0, 32'h0);
    access(32'hFFFFFEFE, 32'h0, 2'd1, 1'b0, 32'h0000FEFF, 1'b0, 3);

    beat(32'hFFFFFDFE, 4'b0011, 1'b0, 32'h0);
    access(32'hFFFFFDFE, 32'h0, 2'd1, 1'b0, 32'h00003344, 1'b0, 2);

    beat(32'hFFFFFEFF, 4'b0001, 1'b0, 32'h0);
    access(32'hFFFFFEFF, 32'h0, 2'd0, 1'b0, 32'h000000FF, 1'b0, 2);

    beat(32'hFFFFFE40, 4'b1000, 1'b1, 32'h12345678);
    beat(32'hFFFFFE41, 4'b0100, 1'b1, 32'h12345678);
    access(32'hFFFFFE40, 32'h12345678, 2'd1, 1'b1, 32'h0, 1'b0, 3);

    busy_cfg = 3;
    busy_gen++;
    beat(32'hFFFFFE40, 4'b1000, 1'b0, 32'h0);
    access(32'hFFFFFE40, 32'h0, 2'd0, 1'b0, 32'h40000000, 1'b0, 5);

    busy_cfg = 16;
    busy_gen++;
    access(32'hFFFFFE40, 32'h0, 2'd0, 1'b0, 32'h0, 1'b1, 17);

    beat(32'hFFFFFE40, 4'b1000, 1'b0, 32'h0);
    issue(32'hFFFFFE40, 32'h0, 2'd2, 1'b0);
    n = 0;
    while (exp_beat.size() != 0 && n < 50) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check("reset_test_first_beat", exp_beat.size(), 0);
    RST_N = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check("midaccess_reset_outputs",
          {M_DO, M_ACK, M_ERR, M_BUSY, IBUS_A, IBUS_DI, IBUS_BA, IBUS_WE, IBUS_REQ}, '0);
    RST_N = 1'b1;
    repeat (8) @(negedge CLK);

    beat(32'hFFFFFE12, 4'b0010, 1'b0, 32'h0);
    beat(32'hFFFFFE13, 4'b0001, 1'b0, 32'h0);
    access(32'hFFFFFE12, 32'h0, 2'd1, 1'b0, 32'h0000ABCD, 1'b0, 3);

    repeat (4) @(negedge CLK);
    check("beats_outstanding", exp_beat.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
